// File: rtl/spi_mem_fsm.sv
// spi_mem_fsm: transaction sequencer for the SPI data memory.
// Counts s_clk rises under CS low, then strobes the datapath enables.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   s_clk            conditioned serial clock level (clk domain)
//   CS               chip select, active low
//   read_write       R/W bit from shift register (1 = read)
//   miso_buff        MISO buffer enable
//   ad_we            address latch write enable
//   sr_we            shift register parallel load enable
//   dm_we            data memory write enable
module spi_mem_fsm #(
  parameter int WORD_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_clk,
  input  logic CS,
  input  logic read_write,
  output logic miso_buff,
  output logic ad_we,
  output logic sr_we,
  output logic dm_we
);

  localparam int CW = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS);

  typedef enum logic [2:0] {
    GET,
    GOT,
    READ1,
    READ2,
    READ3,
    WRITE1,
    WRITE2,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_clk_q;
  logic          rise;
  logic [CW-1:0] cnt_inc;
  logic          cnt_full;

  assign rise     = s_clk & ~s_clk_q;
  assign cnt_inc  = cnt_q + {{(CW-1){1'b0}}, rise};
  assign cnt_full = (cnt_inc == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET;
      cnt_q   <= '0;
      s_clk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_clk_q <= s_clk;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (CS) begin
      // deselect aborts any phase and discards partial counts
      state_d = GET;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        GET: begin
          cnt_d = cnt_inc;
          if (cnt_full) begin
            cnt_d   = '0;
            state_d = GOT;
          end
        end
        GOT: begin
          state_d = read_write ? READ1 : WRITE1;
        end
        READ1: begin
          state_d = READ2;
        end
        READ2: begin
          state_d = READ3;
        end
        READ3: begin
          cnt_d = cnt_inc;
          if (cnt_full) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        WRITE1: begin
          cnt_d = cnt_inc;
          if (cnt_full) begin
            cnt_d   = '0;
            state_d = WRITE2;
          end
        end
        WRITE2: begin
          state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = GET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ad_we     = 1'b0;
    sr_we     = 1'b0;
    miso_buff = 1'b0;
    dm_we     = 1'b0;
    unique case (1'b1)
      (state_q == GOT):    ad_we     = 1'b1;
      (state_q == READ2):  sr_we     = 1'b1;
      (state_q == READ3):  miso_buff = 1'b1;
      (state_q == WRITE2): dm_we     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_mem_fsm.sv
// tb_spi_mem_fsm: randomized scoreboard bench for spi_mem_fsm.
// Each output pulse is reduced to (kind, start rise, rises, clks).
module tb_spi_mem_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic s_clk;
  logic CS;
  logic read_write;
  logic miso_buff;
  logic ad_we;
  logic sr_we;
  logic dm_we;

  spi_mem_fsm #(.WORD_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_clk     (s_clk),
    .CS        (CS),
    .read_write(read_write),
    .miso_buff (miso_buff),
    .ad_we     (ad_we),
    .sr_we     (sr_we),
    .dm_we     (dm_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int start;
    int len;
    int clks;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  rises = 0;

  localparam int K_AD = 0;
  localparam int K_SR = 1;
  localparam int K_MI = 2;
  localparam int K_DM = 3;

  function automatic string kname(input int k);
    case (k)
      K_AD:    return "ad_we";
      K_SR:    return "sr_we";
      K_MI:    return "miso_buff";
      default: return "dm_we";
    endcase
  endfunction

  task automatic push(input int k, input int s, input int l, input int c);
    ev_t e;
    e.kind  = k;
    e.start = s;
    e.len   = l;
    e.clks  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    logic [3:0] o;
    o = {dm_we, miso_buff, sr_we, ad_we};
    n_cmp++;
    if (o !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s: outputs got %b want 0000", name, o);
    end
  endtask

  // monitor: reduce output pulses to events and score them
  initial begin : monitor
    int act[4];
    int st[4];
    int cl[4];
    logic [3:0] o;
    ev_t e;
    for (int k = 0; k < 4; k++) begin
      act[k] = 0;
      st[k]  = 0;
      cl[k]  = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      o = {dm_we, miso_buff, sr_we, ad_we};
      if ($countones(o) > 1 || $isunknown(o)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL onehot: outputs got %b want at most one high", o);
      end
      for (int k = 0; k < 4; k++) begin
        if (o[k] === 1'b1) begin
          if (act[k] == 0) begin
            act[k] = 1;
            st[k]  = rises;
            cl[k]  = 0;
          end
          cl[k]++;
        end else if (act[k] != 0) begin
          act[k] = 0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected %s: start %0d rises %0d clks %0d want none",
                     kname(k), st[k], rises - st[k], cl[k]);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.start != st[k] || e.len != rises - st[k] ||
                (e.clks != 0 && e.clks != cl[k])) begin
              n_bad++;
              $display("FAIL event: got %s start %0d rises %0d clks %0d want %s start %0d rises %0d clks %0d",
                       kname(k), st[k], rises - st[k], cl[k],
                       kname(e.kind), e.start, e.len, e.clks);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  task automatic pulse();
    @(negedge clk);
    s_clk = 1'b1;
    rises++;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    s_clk = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic start_txn(input logic rw);
    @(negedge clk);
    read_write = rw;
    CS = 1'b0;
    rises = 0;
  endtask

  // deselect, with some s_clk activity the DUT must ignore
  task automatic end_txn();
    repeat (4) @(negedge clk);
    CS = 1'b1;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      s_clk = 1'b1;
      @(negedge clk);
      s_clk = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input int extra);
    push(K_AD, 8, 0, 1);
    push(K_SR, 8, 0, 1);
    push(K_MI, 8, 8, 0);
    pulses(8);
    repeat (4) @(negedge clk);
    pulses(8);
    pulses(extra);
  endtask

  task automatic do_write();
    push(K_AD, 8, 0, 1);
    push(K_DM, 16, 0, 1);
    pulses(8);
    repeat (4) @(negedge clk);
    pulses(8);
  endtask

  task automatic txn_abort();
    start_txn(1'($urandom_range(0, 1)));
    pulses(4);
    @(negedge clk);
    CS = 1'b1;
    repeat (2) @(negedge clk);
    CS = 1'b0;
    rises = 0;
    read_write = 1'b0;
    do_write();
    end_txn();
  endtask

  task automatic txn_reset();
    int k;
    k = $urandom_range(1, 6);
    start_txn(1'b1);
    push(K_AD, 8, 0, 1);
    push(K_SR, 8, 0, 1);
    push(K_MI, 8, k, 0);
    pulses(8);
    repeat (4) @(negedge clk);
    pulses(k);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    CS = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_txn(1'b0);
    do_write();
    end_txn();
  endtask

  task automatic run(input int sel);
    case (sel)
      0: begin
        start_txn(1'b1);
        do_read(0);
        end_txn();
      end
      1: begin
        start_txn(1'b0);
        do_write();
        end_txn();
      end
      2: begin
        start_txn(1'b1);
        do_read(10);
        end_txn();
        start_txn(1'b0);
        do_write();
        end_txn();
      end
      3: txn_abort();
      default: txn_reset();
    endcase
  endtask

  initial begin : stim
    rst_n = 1'b0;
    CS = 1'($urandom_range(0, 1));
    s_clk = 1'($urandom_range(0, 1));
    read_write = 1'($urandom_range(0, 1));
    #3;
    check_idle("reset_async");
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    CS = 1'b1;
    s_clk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("reset_release");
    for (int i = 0; i < 5; i++) run(i);
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 4)));
    repeat (6) @(negedge clk);
    check_idle("final_idle");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d pending events want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
